reg_write_demux: RTL and testbench

REG_WRITE_DEMUX -- requirements
Module: reg_write_demux

---
 rtl/reg_write_demux_if.sv | 12 +
 rtl/reg_write_demux.sv | 103 ++++++++++
 tb/tb_reg_write_demux.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_write_demux_if.sv
// rtl/reg_write_demux_if.sv - register write request handshake (valid/ready with addr and data)
interface reg_write_demux_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_addr;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, in_addr, in_data, input in_ready);
  modport slave  (input in_valid, in_addr, in_data, output in_ready);
endinterface

// File: rtl/reg_write_demux.sv
// rtl/reg_write_demux.sv - 2-entry write buffer issuing one-hot register write enables
// with a pending-write lookup for the read port.
module reg_write_demux #(
  parameter int WIDTH = 64,
  parameter int NREGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  reg_write_demux_if.slave  req,
  input  logic              stall,
  output logic [NREGS-1:0]  wr_en,
  output logic [WIDTH-1:0]  wr_data,
  input  logic [4:0]        rd_addr,
  output logic              pend_hit,
  output logic [1:0]        count
);

  localparam logic [4:0] ZERO_REG = 5'd31;

  logic [4:0]       addr_q [2];
  logic [4:0]       addr_d [2];
  logic [WIDTH-1:0] data_q [2];
  logic [WIDTH-1:0] data_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [NREGS-1:0] wr_en_q, wr_en_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;

  logic             in_ready;
  logic             push;
  logic             pop;
  logic [31:0]      dec;
  logic             hit;

  // Ready looks only at registered occupancy so a same-cycle issue never frees a slot.
  assign in_ready     = reset && (count_q != 2'd2);
  assign req.in_ready = in_ready;

  always_comb begin
    push      = req.in_valid && in_ready;
    pop       = (count_q != 2'd0) && !stall;
    dec       = 32'd1 << addr_q[rd_ptr_q];
    addr_d    = addr_q;
    data_d    = data_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    wr_en_d   = '0;
    wr_data_d = wr_data_q;
    if (pop) begin
      wr_data_d = data_q[rd_ptr_q];
      if (addr_q[rd_ptr_q] != ZERO_REG) begin
        wr_en_d = dec[NREGS-1:0];
      end
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push) begin
      addr_d[wr_ptr_q] = req.in_addr;
      data_d[wr_ptr_q] = req.in_data;
      wr_ptr_d         = ~wr_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // With one entry only the slot under the read pointer is live.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (((count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'(i))))
          && (addr_q[i] == rd_addr)) begin
        hit = 1'b1;
      end
    end
    pend_hit = hit && (rd_addr != ZERO_REG);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
    end else begin
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;
  assign count   = count_q;

endmodule

// File: tb/tb_reg_write_demux.sv
// tb/tb_reg_write_demux.sv - directed and randomized checks of reg_write_demux against a queue model
module tb_reg_write_demux;
  localparam int WIDTH = 64;
  localparam int NREGS = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             stall = 1'b0;
  logic [4:0]       rd_addr = 5'd0;
  logic [NREGS-1:0] wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             pend_hit;
  logic [1:0]       count;

  int checks = 0;
  int failures = 0;

  reg_write_demux_if #(.WIDTH(WIDTH)) bus ();

  reg_write_demux #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .req      (bus),
    .stall    (stall),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .pend_hit (pend_hit),
    .count    (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]       a;
    logic [WIDTH-1:0] d;
  } ent_t;

  ent_t             q[$];
  logic [NREGS-1:0] exp_wr_en = '0;
  logic [WIDTH-1:0] exp_wr_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue; issue takes the front, push appends.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      exp_wr_en   = '0;
      exp_wr_data = '0;
    end else begin
      automatic bit   do_push = bus.in_valid && (q.size() < 2);
      automatic ent_t e;
      exp_wr_en = '0;
      if (q.size() > 0 && !stall) begin
        e = q.pop_front();
        exp_wr_data = e.d;
        if (e.a != 5'd31) exp_wr_en[e.a] = 1'b1;
      end
      if (do_push) begin
        e.a = bus.in_addr;
        e.d = bus.in_data;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    automatic bit hit = 1'b0;
    foreach (q[i]) if (q[i].a == rd_addr && rd_addr != 5'd31) hit = 1'b1;
    check("count", 64'(count), 64'(q.size()));
    check("in_ready", 64'(bus.in_ready), 64'(rst_n && q.size() < 2));
    check("wr_en", 64'(wr_en), 64'(exp_wr_en));
    check("wr_data", wr_data, exp_wr_data);
    check("pend_hit", 64'(pend_hit), 64'(hit));
    check("wr_en_onehot", 64'($countones(wr_en) <= 1), 64'd1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [4:0] a, input logic [63:0] d);
    bus.in_valid = v;
    bus.in_addr  = a;
    bus.in_data  = d;
  endtask

  initial begin
    req(1'b0, 5'd0, 64'd0);
    #3;
    check("rst_count", 64'(count), 64'd0);
    check("rst_ready", 64'(bus.in_ready), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_data", wr_data, 64'd0);
    check("rst_pend", 64'(pend_hit), 64'd0);
    cyc();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 64'(bus.in_ready), 64'd1);
    check("post_rst_count", 64'(count), 64'd0);

    // single write to r5
    req(1'b1, 5'd5, 64'hA5);
    cyc();
    check("a5_count", 64'(count), 64'd1);
    check("a5_noearly", 64'(wr_en), 64'd0);
    req(1'b0, 5'd0, 64'd0);
    cyc();
    check("a5_wr_en", 64'(wr_en), 64'h20);
    check("a5_wr_data", wr_data, 64'hA5);
    cyc();
    check("a5_wr_en_off", 64'(wr_en), 64'd0);
    check("a5_hold", wr_data, 64'hA5);

    // fill under stall, third request dropped
    stall = 1'b1;
    req(1'b1, 5'd3, 64'h33);
    cyc();
    req(1'b1, 5'd7, 64'h77);
    cyc();
    check("full_count", 64'(count), 64'd2);
    check("full_ready", 64'(bus.in_ready), 64'd0);
    req(1'b1, 5'd9, 64'h99);
    cyc();
    check("full_drop", 64'(count), 64'd2);
    req(1'b0, 5'd0, 64'd0);
    stall = 1'b0;
    cyc();
    check("drain0", 64'(wr_en), 64'h8);
    cyc();
    check("drain1", 64'(wr_en), 64'h80);
    check("drain1_data", wr_data, 64'h77);
    cyc();
    check("drain_done", 64'(wr_en), 64'd0);
    check("drain_count", 64'(count), 64'd0);

    // zero register consumed silently
    req(1'b1, 5'd31, 64'hFF);
    cyc();
    req(1'b0, 5'd0, 64'd0);
    cyc();
    check("r31_wr_en", 64'(wr_en), 64'd0);
    check("r31_wr_data", wr_data, 64'hFF);
    check("r31_count", 64'(count), 64'd0);

    // simultaneous push and pop
    req(1'b1, 5'd9, 64'h9);
    cyc();
    req(1'b1, 5'd10, 64'hA);
    cyc();
    check("pp_count", 64'(count), 64'd1);
    check("pp_wr_en0", 64'(wr_en), 64'h200);
    req(1'b0, 5'd0, 64'd0);
    cyc();
    check("pp_wr_en1", 64'(wr_en), 64'h400);

    // pending-write lookup
    stall = 1'b1;
    req(1'b1, 5'd12, 64'hC);
    cyc();
    req(1'b0, 5'd0, 64'd0);
    rd_addr = 5'd12;
    #1 check("pend_12", 64'(pend_hit), 64'd1);
    rd_addr = 5'd31;
    #1 check("pend_31", 64'(pend_hit), 64'd0);
    rd_addr = 5'd13;
    #1 check("pend_13", 64'(pend_hit), 64'd0);
    rd_addr = 5'd12;
    stall = 1'b0;
    cyc();
    check("pend_issued_wr", 64'(wr_en), 64'h1000);
    check("pend_issued", 64'(pend_hit), 64'd0);

    // reset with a full buffer
    stall = 1'b1;
    req(1'b1, 5'd1, 64'h1);
    cyc();
    req(1'b1, 5'd2, 64'h2);
    cyc();
    req(1'b0, 5'd0, 64'd0);
    check("prerst_count", 64'(count), 64'd2);
    rst_n = 1'b0;
    #1 check("midrst_count", 64'(count), 64'd0);
    cyc();
    rst_n = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("postrst_quiet", 64'(wr_en), 64'd0);
    end

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      automatic int r = $urandom_range(0, 9);
      logic [4:0] a;
      a = (r < 4) ? 5'($urandom_range(0, 3)) : (r == 4) ? 5'd31 : 5'($urandom);
      req($urandom_range(0, 9) < 6, a, {$urandom, $urandom});
      stall   = ($urandom_range(0, 9) < 3);
      rd_addr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      cyc();
    end
    rst_n = 1'b1;
    req(1'b0, 5'd0, 64'd0);
    stall = 1'b0;
    cyc();
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
